// File: rtl/reset_conditioner_pkg.sv
// Shared types and constants for the reset conditioner.
// Holds the FSM state encoding and the width of the button reset counter.
package reset_conditioner_pkg;

   localparam int RESET_COUNT_W = 8;

   typedef enum logic [1:0] {
      ST_POR,
      ST_RUN,
      ST_HELD,
      ST_STRETCH
   } rc_state_t;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer and debouncer for the active-low board reset button.
// deb_level is the accepted level one cycle ahead of the registered btn_pressed.
module debounce #(
   parameter int DEBOUNCE_CYCLES = 4096,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n,
   output logic deb_level,
   output logic btn_pressed
);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] stable_cnt;
   logic             differs;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Synchronizer stage: both flops idle at the released level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= btn_n;
         sync_p1 <= sync_p0;
      end
   end

   assign differs = (~sync_p1) != deb_level;

   // Debounce stage: any cycle agreeing with the current level restarts the count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_cnt  <= '0;
         deb_level   <= 1'b0;
         btn_pressed <= 1'b0;
      end else begin
         if (!differs) begin
            stable_cnt <= '0;
         end else if (stable_cnt >= STABLE_LAST) begin
            stable_cnt <= '0;
            deb_level  <= ~deb_level;
         end else begin
            stable_cnt <= sat_inc(stable_cnt);
         end
         btn_pressed <= deb_level;
      end
   end

endmodule

// File: rtl/reset_conditioner.sv
// Board reset conditioner: power-up hold, debounced button reset with release
// stretch, and a wrapping count of button-initiated resets.
module reset_conditioner
   import reset_conditioner_pkg::*;
#(
   parameter int POR_CYCLES      = 1024,
   parameter int DEBOUNCE_CYCLES = 4096,
   parameter int STRETCH_CYCLES  = 256,
   parameter int CNT_W           = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     btn_n,
   output logic                     power_on_reset,
   output logic                     btn_pressed,
   output logic [RESET_COUNT_W-1:0] reset_count
);

   localparam longint CNT_MAX = (64'(1) << CNT_W) - 1;

   if (POR_CYCLES < 1 || longint'(POR_CYCLES) > CNT_MAX ||
       DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX ||
       STRETCH_CYCLES < 1 || longint'(STRETCH_CYCLES) > CNT_MAX) begin : g_bad_params
      $fatal(1, "reset_conditioner: cycle parameters must lie in 1 .. 2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_CYCLES);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

   rc_state_t        state;
   rc_state_t        next_state;
   logic [CNT_W-1:0] timer;
   logic             deb_level;
   logic             deb_rise;
   logic             count_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_n       (btn_n),
      .deb_level   (deb_level),
      .btn_pressed (btn_pressed)
   );

   // deb_level is what btn_pressed becomes on this edge, so the FSM and
   // btn_pressed move together and a press landing on POR completion is caught.
   assign deb_rise = deb_level & ~btn_pressed;

   always_comb begin
      next_state = state;
      count_inc  = 1'b0;
      case (state)
         ST_POR: begin
            if (timer >= POR_LAST) next_state = deb_level ? ST_HELD : ST_RUN;
         end
         ST_RUN: begin
            if (deb_rise) begin
               next_state = ST_HELD;
               count_inc  = 1'b1;
            end
         end
         ST_HELD: begin
            if (!deb_level) next_state = ST_STRETCH;
         end
         ST_STRETCH: begin
            if (deb_level)                   next_state = ST_HELD;
            else if (timer >= STRETCH_LAST)  next_state = ST_RUN;
         end
         default: next_state = ST_POR;
      endcase
   end

   // State stage: the timer restarts on every state change
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_POR;
         timer          <= '0;
         power_on_reset <= 1'b1;
         reset_count    <= '0;
      end else begin
         state          <= next_state;
         timer          <= (next_state != state) ? '0 : sat_inc(timer);
         power_on_reset <= (next_state != ST_RUN);
         if (count_inc) reset_count <= reset_count + RESET_COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_reset_conditioner.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle,
// a negedge monitor pops and compares whenever the observed outputs change.
module tb_reset_conditioner;

   logic       clk;
   logic       reset_n;
   logic       btn_n;
   logic       power_on_reset;
   logic       btn_pressed;
   logic [7:0] reset_count;

   typedef struct {
      int         cyc;   // -1: any cycle
      logic       por;
      logic       btn;
      logic [7:0] cnt;
   } ev_t;

   ev_t exp_q[$];
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;

   reset_conditioner #(
      .POR_CYCLES      (8),
      .DEBOUNCE_CYCLES (4),
      .STRETCH_CYCLES  (6),
      .CNT_W           (16)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .btn_n          (btn_n),
      .power_on_reset (power_on_reset),
      .btn_pressed    (btn_pressed),
      .reset_count    (reset_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input int c, input logic p, input logic b, input logic [7:0] n);
      ev_t e;
      e.cyc = c;
      e.por = p;
      e.btn = b;
      e.cnt = n;
      exp_q.push_back(e);
   endtask

   task automatic drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected output changes never seen (next at cyc %0d), required 0",
                  name, exp_q.size(), exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   // Monitor: every change of the observed outputs is one scoreboard event
   initial begin
      logic [9:0] prev;
      logic [9:0] cur;
      bit         seen_first;
      ev_t        e;
      seen_first = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         cur = {power_on_reset, btn_pressed, reset_count};
         if (!seen_first || cur != prev) begin
            seen_first = 1'b1;
            prev       = cur;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got por=%0b btn=%0b cnt=%0d, required no change",
                        cyc, power_on_reset, btn_pressed, reset_count);
            end else begin
               e = exp_q.pop_front();
               if ((e.cyc >= 0 && e.cyc != cyc) || e.por != power_on_reset ||
                   e.btn != btn_pressed || e.cnt != reset_count) begin
                  errors++;
                  $display("FAIL output_change got cyc=%0d por=%0b btn=%0b cnt=%0d, required cyc=%0d por=%0b btn=%0b cnt=%0d",
                           cyc, power_on_reset, btn_pressed, reset_count, e.cyc, e.por, e.btn, e.cnt);
               end
            end
         end
      end
   end

   initial begin
      int         c;
      int         r;
      logic [7:0] n;

      reset_n = 1'b0;
      btn_n   = 1'b1;
      expect_ev(-1, 1'b1, 1'b0, 8'd0);
      tick(3);

      // Power-up: power_on_reset high for 8 sampled cycles after release
      reset_n = 1'b1;
      c = cyc;
      expect_ev(c + 9, 1'b0, 1'b0, 8'd0);
      tick(12);
      drained("power_up");

      // Clean press held 20 cycles: reset at edge 7, release stretched 6 cycles
      btn_n = 1'b0;
      c = cyc;
      expect_ev(c + 7, 1'b1, 1'b1, 8'd1);
      tick(20);
      btn_n = 1'b1;
      r = cyc;
      expect_ev(r + 7, 1'b1, 1'b0, 8'd1);
      expect_ev(r + 13, 1'b0, 1'b0, 8'd1);
      tick(16);
      drained("clean_press");

      // Bounce: 3 low / 1 high, five times, never accepted
      for (int i = 0; i < 5; i++) begin
         btn_n = 1'b0;
         tick(3);
         btn_n = 1'b1;
         tick(1);
      end
      tick(12);
      drained("bounce");

      // Re-press during STRETCH returns to HELD, no count, reset never drops
      btn_n = 1'b0;
      c = cyc;
      expect_ev(c + 7, 1'b1, 1'b1, 8'd2);
      tick(10);
      btn_n = 1'b1;
      r = cyc;
      expect_ev(r + 7, 1'b1, 1'b0, 8'd2);
      tick(4);
      btn_n = 1'b0;
      expect_ev(r + 11, 1'b1, 1'b1, 8'd2);
      tick(10);
      btn_n = 1'b1;
      r = cyc;
      expect_ev(r + 7, 1'b1, 1'b0, 8'd2);
      expect_ev(r + 13, 1'b0, 1'b0, 8'd2);
      tick(16);
      drained("stretch_repress");

      // One-cycle reset_n pulse while HELD: clears and reruns POR
      btn_n = 1'b0;
      c = cyc;
      expect_ev(c + 7, 1'b1, 1'b1, 8'd3);
      tick(10);
      reset_n = 1'b0;
      btn_n   = 1'b1;
      c = cyc;
      expect_ev(c, 1'b1, 1'b0, 8'd0);
      tick(1);
      reset_n = 1'b1;
      c = cyc;
      expect_ev(c + 9, 1'b0, 1'b0, 8'd0);
      tick(12);
      drained("reset_in_held");

      // 256 press/release cycles: reset_count wraps back to 0
      n = 8'd0;
      for (int i = 0; i < 256; i++) begin
         n = n + 8'd1;
         btn_n = 1'b0;
         c = cyc;
         expect_ev(c + 7, 1'b1, 1'b1, n);
         tick(8);
         btn_n = 1'b1;
         r = cyc;
         expect_ev(r + 7, 1'b1, 1'b0, n);
         expect_ev(r + 13, 1'b0, 1'b0, n);
         tick(16);
      end
      tick(4);
      drained("wrap");

      checks++;
      if (reset_count !== 8'd0) begin
         errors++;
         $display("FAIL wrap_final got reset_count=%0d, required 0", reset_count);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_conditioner.md
RESET_CONDITIONER -- requirements
Module: reset_conditioner

Interface
REQ-001 Parameters SHALL be given one per line as name, default, meaning:
- POR_CYCLES, 1024, power-up hold length in clk cycles.
- DEBOUNCE_CYCLES, 4096, cycles a synchronized button level must be stable before it is accepted.
- STRETCH_CYCLES, 256, minimum reset extension after button release.
- CNT_W, 16, shared timer width.
REQ-002 Ports SHALL be given one per line as name, direction, width, meaning:
- clk, input, 1, system clock, all logic on its rising edge.
- reset_n, input, 1, reset, asynchronous and active-low.
- btn_n, input, 1, raw board reset button, active-low, asynchronous to clk, may bounce.
- power_on_reset, output, 1, registered active-high reset to the system core.
- btn_pressed, output, 1, debounced button level, 1 = pressed.
- reset_count, output, 8, number of button-initiated resets, wrapping.

Function
REQ-003 btn_n SHALL pass through a 2-flop synchronizer; both flops reset to 1 (released).
REQ-004 The debounced level SHALL toggle only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any single-cycle return to the current level clears the stability counter to 0.
REQ-005 btn_pressed SHALL be the registered debounced level; a clean press held stable asserts it on the (DEBOUNCE_CYCLES+3)th rising edge after btn_n falls.
REQ-006 The FSM SHALL have the states POR, RUN, HELD and STRETCH.
REQ-007 POR: the timer counts; after exactly POR_CYCLES cycles the FSM goes to HELD if btn_pressed=1, else to RUN.
REQ-008 RUN: a btn_pressed rising edge moves the FSM to HELD and increments reset_count in the same cycle.
REQ-009 HELD: the FSM stays while btn_pressed=1; on btn_pressed=0 it goes to STRETCH with the timer cleared.
REQ-010 STRETCH: after STRETCH_CYCLES cycles the FSM goes to RUN; btn_pressed=1 during STRETCH returns it to HELD without incrementing reset_count.
REQ-011 power_on_reset SHALL be registered as (next_state != RUN), so it changes on the same edge as the state register, with no combinational path from btn_n.
REQ-012 power_on_reset SHALL be 1 for exactly POR_CYCLES cycles after the first clk edge following reset_n release, when no button activity occurs.
REQ-013 reset_count SHALL wrap from 255 to 0 with no saturation or flag.
REQ-014 The timer SHALL saturate rather than wrap if a parameter exceeds 2^CNT_W-1.
REQ-015 An elaboration-time check SHALL reject any of POR_CYCLES, DEBOUNCE_CYCLES or STRETCH_CYCLES that is 0 or that exceeds 2^CNT_W-1.
REQ-016 A press at the exact cycle POR completes SHALL resolve to HELD with reset_count unchanged, because a press during POR is not counted.

Reset
REQ-017 reset_n low SHALL asynchronously force:
- FSM state = POR
- all counters = 0
- power_on_reset = 1
- btn_pressed = 0
- reset_count = 0
- synchronizer flops = 1
REQ-018 reset_n asserted mid-operation, in any state, SHALL abort that state immediately with power_on_reset held high; deassertion SHALL be treated as a fresh power-up.

Structure
REQ-019 A shared package SHALL hold the FSM state enum typedef and the reset_count width constant (8).
REQ-020 The synchronizer and debouncer SHALL form one sub-module, debounce, parameterized by DEBOUNCE_CYCLES and CNT_W; reset_conditioner instantiates it once.

Verification
Directed scenarios use POR_CYCLES=8, DEBOUNCE_CYCLES=4 and STRETCH_CYCLES=6.
REQ-021 Release reset_n, btn_n=1 -> power_on_reset high for exactly 8 cycles then low; reset_count=0.
REQ-022 After POR, hold btn_n low for 20 cycles, then release -> power_on_reset rises at edge 7 after btn_n falls and stays high until 6 cycles after btn_pressed falls; reset_count=1.
REQ-023 Bounce btn_n low for 3 cycles, high for 1, repeated 5 times -> btn_pressed stays 0, power_on_reset stays 0, reset_count=0.
REQ-024 Re-press during STRETCH (cycle 3 of 6) -> FSM returns to HELD, power_on_reset never drops, reset_count unchanged.
REQ-025 Perform 256 complete press/release cycles -> reset_count reads 0 after the last one.
REQ-026 Pulse reset_n low for 1 cycle while in HELD -> power_on_reset stays high, counters and reset_count clear, and an 8-cycle POR reruns.
